serial_tx_framer: RTL and testbench

- Parallel-to-serial asynchronous-frame transmitter for the common_module library.
- Accepts one DATA_W-bit word over a valid/ready handshake. Emits it on a single line as: start bit (0), data LSB-first, one stop bit (1).
- Each bit is held CLKS_PER_BIT clocks.
- Sits between a word producer (register block or FIFO) and an off-chip or inter-block serial line. Idle line level is high.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/serial_tx_framer_bit_timer.sv | 29 ++
 rtl/serial_tx_framer.sv | 121 ++++++++++++
 tb/tb_serial_tx_framer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmit framer.
package serial_pkg;

   // Frame FSM states; the encoding is also visible on the debug state port.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Level driven on the line when no frame is in progress (and for the stop bit).
   localparam logic IDLE_LEVEL = 1'b1;

   // Ceiling log2 for sizing counters; clog2(1) = 0, clog2(2) = 1, clog2(16) = 4.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_tx_framer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module bit_timer
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           en,
   output logic [clog2(CLKS_PER_BIT)-1:0] count,
   output logic                           tc
);

   localparam int CNT_W = clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   assign tc = (count == LAST);

   // Wrap at the terminal count so consecutive bits need no explicit clear.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB-first,
// one stop bit, each bit held CLKS_PER_BIT clocks. Idle line is high.
//
// Handshake: a word is transferred on every clock where tx_valid and tx_ready
// are both high at the rising edge. tx_ready depends only on the state
// register (high exactly in IDLE); tx_valid may rise or fall at any time and
// tx_data is only looked at on the transfer clock.
module serial_tx_framer
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   output logic              busy,
   output logic              done,
   output state_t            state_dbg
);

   localparam int CNT_W = clog2(CLKS_PER_BIT);
   localparam int IDX_W = clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   // done is registered, so it is armed one clock before the last stop clock.
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

   state_t            state, state_next;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic [IDX_W-1:0]  bit_idx, bit_idx_next;
   logic              timer_clr;
   logic              timer_en;
   logic [CNT_W-1:0]  bit_cnt;
   logic              bit_tc;
   logic              txd_next;
   logic              busy_next;
   logic              done_next;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (timer_clr),
      .en   (timer_en),
      .count(bit_cnt),
      .tc   (bit_tc)
   );

   assign tx_ready  = (state == IDLE);
   assign state_dbg = state;

   // Next-state, shift-register and registered-output decode.
   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_idx_next = bit_idx;
      timer_clr    = 1'b0;
      timer_en     = 1'b1;
      case (state)
         IDLE: begin
            timer_clr = 1'b1;
            timer_en  = 1'b0;
            if (tx_valid) begin
               shreg_next   = tx_data;
               bit_idx_next = '0;
               state_next   = START;
            end
         end
         START: begin
            if (bit_tc) state_next = DATA;
         end
         DATA: begin
            if (bit_tc) begin
               shreg_next = shreg >> 1;
               if (bit_idx == LAST_IDX) begin
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx + 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_tc) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Line level follows the state being entered so txd lines up with it.
      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shreg_next[0];
         default: txd_next = IDLE_LEVEL;
      endcase
      busy_next = (state_next != IDLE);
      done_next = (state == STOP) && (bit_cnt == PRE_LAST);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         txd     <= IDLE_LEVEL;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         bit_idx <= bit_idx_next;
         txd     <= txd_next;
         busy    <= busy_next;
         done    <= done_next;
      end
   end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: instance A (DATA_W=8, CLKS_PER_BIT=4) and
// instance B (DATA_W=1, CLKS_PER_BIT=2). Expected per-clock line samples
// {txd, done, tx_ready} are queued at each handshake and popped by monitors.
module tb_serial_tx_framer;
   import serial_pkg::*;

   localparam int CPB_A = 4;
   localparam int DW_A  = 8;
   localparam int CPB_B = 2;
   localparam int DW_B  = 1;

   // Clock and reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW_A-1:0] tx_data_a  = '0;
   logic            tx_valid_a = 1'b0;
   logic            tx_ready_a, txd_a, busy_a, done_a;
   state_t          state_a;

   logic [DW_B-1:0] tx_data_b  = '0;
   logic            tx_valid_b = 1'b0;
   logic            tx_ready_b, txd_b, busy_b, done_b;
   state_t          state_b;

   serial_tx_framer #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A)) dut_a (
      .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
      .tx_ready(tx_ready_a), .txd(txd_a), .busy(busy_a), .done(done_a),
      .state_dbg(state_a)
   );

   serial_tx_framer #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB_B)) dut_b (
      .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
      .tx_ready(tx_ready_b), .txd(txd_b), .busy(busy_b), .done(done_b),
      .state_dbg(state_b)
   );

   // Scoreboard state
   int         checks   = 0;
   int         failures = 0;
   logic [2:0] exp_q_a[$];
   logic [2:0] exp_q_b[$];
   int         t_q_a[$];
   int         done_cnt_a = 0;
   int         done_cnt_b = 0;
   logic       busy_a_q = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference frame: start, data LSB-first, stop; done on the last stop clock.
   task automatic push_frame(input logic [15:0] w, input int dw, input int cpb, input bit to_b);
      logic [15:0] s;
      logic        lvl;
      logic        dn;
      s = w;
      for (int b = 0; b < dw + 2; b++) begin
         if (b == 0) lvl = 1'b0;
         else if (b == dw + 1) lvl = 1'b1;
         else lvl = s[0];
         for (int c = 0; c < cpb; c++) begin
            dn = (b == dw + 1) && (c == cpb - 1);
            if (to_b) exp_q_b.push_back({lvl, dn, 1'b0});
            else      exp_q_a.push_back({lvl, dn, 1'b0});
         end
         if (b != 0) s = s >> 1;
      end
   endtask

   // Driver tasks: present a word, wait (bounded) for the transfer clock.
   task automatic send_a(input logic [DW_A-1:0] w, input bit keep_valid, output int hs);
      bit got;
      got = 1'b0;
      hs  = -1;
      @(posedge clk); #1;
      tx_data_a  = w;
      tx_valid_a = 1'b1;
      for (int n = 0; n < 500 && !got; n++) begin
         @(negedge clk);
         if (tx_ready_a === 1'b1) got = 1'b1;
      end
      chk("a_handshake_seen", got, 1);
      if (got) begin
         hs = cyc;
         push_frame(16'(w), DW_A, CPB_A, 1'b0);
         t_q_a.push_back(hs + 1);
      end
      @(posedge clk); #1;
      if (!keep_valid) tx_valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [DW_B-1:0] w);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      tx_data_b  = w;
      tx_valid_b = 1'b1;
      for (int n = 0; n < 500 && !got; n++) begin
         @(negedge clk);
         if (tx_ready_b === 1'b1) got = 1'b1;
      end
      chk("b_handshake_seen", got, 1);
      if (got) push_frame(16'(w), DW_B, CPB_B, 1'b1);
      @(posedge clk); #1;
      tx_valid_b = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 300 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); n++) begin
         @(negedge clk);
      end
      chk({name, "_drain_a"}, exp_q_a.size(), 0);
      chk({name, "_drain_b"}, exp_q_b.size(), 0);
   endtask

   // Monitor A: frame start time, per-clock samples while busy, idle level otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy_a && !busy_a_q) begin
            chk("a_start_expected", t_q_a.size() > 0, 1);
            if (t_q_a.size() > 0) chk("a_start_cycle", cyc, t_q_a.pop_front());
         end
         if (busy_a) begin
            chk("a_sample_expected", exp_q_a.size() > 0, 1);
            if (exp_q_a.size() > 0) chk("a_sample", {txd_a, done_a, tx_ready_a}, exp_q_a.pop_front());
         end else begin
            chk("a_idle", {txd_a, done_a, tx_ready_a}, 3'b101);
         end
         if (done_a === 1'b1) done_cnt_a++;
      end
      busy_a_q = busy_a && !rst;
   end

   // Monitor B
   always @(negedge clk) begin
      if (!rst) begin
         if (busy_b) begin
            chk("b_sample_expected", exp_q_b.size() > 0, 1);
            if (exp_q_b.size() > 0) chk("b_sample", {txd_b, done_b, tx_ready_b}, exp_q_b.pop_front());
         end else begin
            chk("b_idle", {txd_b, done_b, tx_ready_b}, 3'b101);
         end
         if (done_b === 1'b1) done_cnt_b++;
      end
   end

   // Stimulus
   initial begin
      int h1, h2, h3;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state and a long idle stretch
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_outputs", {txd_a, tx_ready_a, busy_a, done_a}, 4'b1100);
         if (i == 0) chk("idle_state", state_a, IDLE);
      end

      // Single frame 0xA5
      send_a(8'hA5, 1'b0, h1);
      drain("a5");

      // Held tx_valid: 0x00 then 0xFF back-to-back
      send_a(8'h00, 1'b1, h1);
      send_a(8'hFF, 1'b0, h2);
      chk("b2b_spacing", h2 - h1, 41);
      drain("b2b");

      // tx_data changes mid-frame must not disturb 0x81
      send_a(8'h81, 1'b0, h1);
      repeat (10) @(posedge clk);
      #1 tx_data_a = 8'h3C;
      drain("mid_change");
      repeat (20) @(negedge clk);
      chk("no_extra_frame", t_q_a.size(), 0);

      // Reset during data bit 3 (cycles h3+17..h3+20)
      send_a(8'h5A, 1'b0, h3);
      repeat (16) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q_a.delete();
      @(negedge clk);
      chk("rst_mid_outputs", {txd_a, busy_a, tx_ready_a, done_a}, 4'b1010);
      chk("rst_mid_state", state_a, IDLE);
      repeat (10) @(negedge clk);
      send_a(8'hC3, 1'b0, h1);
      drain("after_rst");

      // Minimal configuration: DATA_W=1, CLKS_PER_BIT=2
      send_b(1'b0);
      drain("b_zero");
      send_b(1'b1);
      drain("b_one");

      repeat (5) @(negedge clk);
      chk("done_count_a", done_cnt_a, 5);
      chk("done_count_b", done_cnt_b, 2);
      chk("start_queue_empty", t_q_a.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
